// File: rtl/cavlc_pkg.sv
// Shared constants and state encoding for the CAVLC coefficient statistics block.
package cavlc_pkg;

   localparam int BLK_16  = 16;
   localparam int BLK_AC  = 15;
   localparam int BLK_CDC = 4;
   localparam int MAX_T1  = 3;

   localparam int TC_W = 5;
   localparam int TZ_W = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = S_IDLE,
      SCAN = S_SCAN,
      DONE = S_DONE
   } state_t;

endpackage

// File: rtl/cavlc_t1_tracker.sv
// Trailing-ones tracker: counts up to three leading +/-1 values in scan order
// and records their signs; any larger level closes the window.
module cavlc_t1_tracker
   import cavlc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       beat,
   input  logic       clear,
   input  logic       nz,
   input  logic       unit,
   input  logic       sign,
   output logic [1:0] trailing_ones,
   output logic [2:0] t1_signs
);

   logic t1_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         trailing_ones <= '0;
         t1_signs      <= '0;
         t1_done       <= 1'b0;
      end else if (clear) begin
         trailing_ones <= '0;
         t1_signs      <= '0;
         t1_done       <= 1'b0;
      end else if (beat && nz && !t1_done) begin
         if (unit) begin
            t1_signs[trailing_ones] <= sign;
            trailing_ones           <= trailing_ones + 2'd1;
            if (trailing_ones == 2'(MAX_T1 - 1))
               t1_done <= 1'b1;
         end else begin
            t1_done <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cavlc_coeff_stats.sv
// CAVLC statistics for one block of coefficients arriving in reverse zig-zag order.
//   state | meaning
//   IDLE  | waiting for the first beat (index NUM_COEFF-1)
//   SCAN  | accepting beats, counter walking down to index 0
//   DONE  | statistics presented, held until out_ready
module cavlc_coeff_stats
   import cavlc_pkg::*;
#(
   parameter int COEFF_W   = 16,
   parameter int NUM_COEFF = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [COEFF_W-1:0] in_coeff,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [TC_W-1:0]           total_coeff,
   output logic [1:0]                trailing_ones,
   output logic [2:0]                t1_signs,
   output logic [TZ_W-1:0]           total_zeros,
   output logic [BLK_16-1:0]         nz_map
);

   // Unsupported block sizes fall back to a full 4x4 scan.
   localparam bit         LEGAL_N  = (NUM_COEFF == BLK_16) || (NUM_COEFF == BLK_AC) ||
                                     (NUM_COEFF == BLK_CDC);
   localparam logic [3:0] LAST_IDX = LEGAL_N ? 4'(NUM_COEFF - 1) : 4'(BLK_16 - 1);

   localparam logic signed [COEFF_W-1:0] C_POS_ONE = COEFF_W'(1);
   localparam logic signed [COEFF_W-1:0] C_NEG_ONE = '1;

   state_t     state;
   logic [3:0] idx;
   logic       seen_nz;
   logic       beat;
   logic       nz;
   logic       unit;
   logic       clear;

   assign beat  = in_valid && in_ready;
   assign nz    = (in_coeff != '0);
   assign unit  = (in_coeff == C_POS_ONE) || (in_coeff == C_NEG_ONE);
   assign clear = (state == DONE) && out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         idx         <= LAST_IDX;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         total_coeff <= '0;
         total_zeros <= '0;
         nz_map      <= '0;
         seen_nz     <= 1'b0;
      end else begin
         case (state)
            IDLE, SCAN: begin
               in_ready <= 1'b1;
               if (beat) begin
                  if (nz) begin
                     total_coeff <= total_coeff + TC_W'(1);
                     nz_map[idx] <= 1'b1;
                     seen_nz     <= 1'b1;
                  end else if (seen_nz) begin
                     total_zeros <= total_zeros + TZ_W'(1);
                  end
                  if (idx == 4'd0) begin
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     state <= SCAN;
                     idx   <= idx - 4'd1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state       <= IDLE;
                  in_ready    <= 1'b1;
                  out_valid   <= 1'b0;
                  idx         <= LAST_IDX;
                  total_coeff <= '0;
                  total_zeros <= '0;
                  nz_map      <= '0;
                  seen_nz     <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   cavlc_t1_tracker u_t1 (
      .clk           (clk),
      .rst           (rst),
      .beat          (beat),
      .clear         (clear),
      .nz            (nz),
      .unit          (unit),
      .sign          (in_coeff[COEFF_W-1]),
      .trailing_ones (trailing_ones),
      .t1_signs      (t1_signs)
   );

endmodule
